// File: rtl/cpu_pkg.sv
// Shared RV32I control definitions: ALU operation codes, base opcodes and
// the multicycle controller state type.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SLL = 4'b0001,
        ALU_SLT = 4'b0010,
        ALU_XOR = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_OR  = 4'b0110,
        ALU_AND = 4'b0111,
        ALU_SUB = 4'b1000
    } alu_ops;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } ctrl_state_e;

    // Immediate format follows the opcode alone, independent of phase.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return 2'b01;
            OP_B:    return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder for R-type and I-type ALU instructions;
// flags encodings this datapath cannot execute.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_control,
    output logic       illegal_alu
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal_alu = 1'b0;
        case (funct3)
            3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b100:  alu_control = ALU_XOR;
            // Arithmetic right shift is not provided by the ALU.
            3'b101:  begin
                alu_control = ALU_SRL;
                illegal_alu = funct7b5;
            end
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: illegal_alu = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU and unified memory
// port across instruction phases, with a req/ready memory handshake.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control,
    output logic       instr_done,
    output logic       illegal
);

    ctrl_state_e state_q, state_d;

    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic       req_c, wr_c, irw_c, pcw_c, rw_c, done_c;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (state_q == S_EXECR),
        .alu_control (dec_alu),
        .illegal_alu (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_c       = 1'b0;
        wr_c        = 1'b0;
        irw_c       = 1'b0;
        pcw_c       = 1'b0;
        rw_c        = 1'b0;
        done_c      = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                req_c      = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw_c      = mem_ready;
                pcw_c      = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                req_c   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                rw_c       = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                req_c   = 1'b1;
                wr_c    = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = dec_alu;
                state_d     = dec_illegal ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                rw_c    = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                case (funct3)
                    3'b000: begin
                        pcw_c   = zero;
                        done_c  = 1'b1;
                        state_d = S_FETCH;
                    end
                    3'b001: begin
                        pcw_c   = !zero;
                        done_c  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw_c     = 1'b1;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // Strobes are forced low combinationally so reset silences them at once.
    assign mem_req    = req_c & reset;
    assign mem_write  = wr_c & req_c & reset;
    assign ir_write   = irw_c & reset;
    assign pc_write   = pcw_c & reset;
    assign reg_write  = rw_c & reset;
    assign instr_done = done_c & reset;
    assign imm_src    = imm_src_of(op);

endmodule
